// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC register, issues one outstanding imem
// fetch at a time and holds the returned instruction until decode takes it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] redirect_target;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d        = state_q;
        kill_d         = kill_q;
        req_pc_d       = req_pc_q;
        inst_d         = inst_q;
        inst_pc_d      = inst_pc_q;
        pc_next        = pc;
        imem_req_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                pc_next = RESET_PC;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end else begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        req_pc_d = pc;
                        pc_next  = pc + 32'd4;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    kill_d  = 1'b1;
                end
                // A redirect landing with the response also kills that response.
                if (imem_rsp_valid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = req_pc_q;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        inst_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            kill_q       <= 1'b0;
            req_pc_q     <= 32'h0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            req_pc_q     <= req_pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign imem_req_addr = pc;
    assign inst_valid    = inst_valid_q;
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a local PC register closes the pc/pc_next
// loop while imem and decode are driven step by step from one initial block.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int vectorCount;
    int miscompareCount;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .pc_next        (pc_next),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the program_counter register that loads pc_next every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= 32'h0;
        else       pc <= pc_next;
    end

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected)
        else begin
            miscompareCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic reqCycle(input string tag, input logic [31:0] expAddr, input logic [31:0] expNext);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
        checkOutput({tag, "_req_addr"}, imem_req_addr, expAddr);
        checkOutput({tag, "_req_pc_next"}, pc_next, expNext);
        checkOutput({tag, "_req_inst_valid"}, 32'(inst_valid), 32'd0);
        applyStimulus();
        imem_req_ready = 1'b0;
    endtask

    task automatic waitCycle(input string tag, input logic [31:0] data, input logic [31:0] expNext);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        #1;
        checkOutput({tag, "_wait_req_valid"}, 32'(imem_req_valid), 32'd0);
        checkOutput({tag, "_wait_pc_next"}, pc_next, expNext);
        checkOutput({tag, "_wait_inst_valid"}, 32'(inst_valid), 32'd0);
        applyStimulus();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic holdCycle(input string tag, input logic ready, input logic [31:0] expPc,
                             input logic [31:0] expInst, input logic [31:0] expNext);
        inst_ready = ready;
        #1;
        checkOutput({tag, "_hold_inst_valid"}, 32'(inst_valid), 32'd1);
        checkOutput({tag, "_hold_inst_pc"}, inst_pc, expPc);
        checkOutput({tag, "_hold_inst"}, inst, expInst);
        checkOutput({tag, "_hold_pc_next"}, pc_next, expNext);
        applyStimulus();
        inst_ready = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pc_next"}, pc_next, 32'h0);
        checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        checkOutput({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        checkOutput({tag, "_inst"}, inst, 32'h0000_0013);
        checkOutput({tag, "_inst_pc"}, inst_pc, 32'h0);
    endtask

    initial begin
        vectorCount     = 0;
        miscompareCount = 0;
        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;

        // Reset state, including a redirect that must be ignored in IDLE.
        applyStimulus();
        applyStimulus();
        checkResetValues("reset");
        reset          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0444;
        #1;
        checkOutput("idle_pc_next", pc_next, 32'h0);
        checkOutput("idle_req_valid", 32'(imem_req_valid), 32'd0);
        applyStimulus();
        redirect_valid = 1'b0;

        // Free-run fetches of 0x0, 0x4, 0x8.
        reqCycle("f0", 32'h0, 32'h4);
        waitCycle("f0", memWord(32'h0), 32'h4);
        holdCycle("f0", 1'b1, 32'h0, memWord(32'h0), 32'h4);
        reqCycle("f4", 32'h4, 32'h8);
        waitCycle("f4", memWord(32'h4), 32'h8);
        holdCycle("f4", 1'b1, 32'h4, memWord(32'h4), 32'h8);
        reqCycle("f8", 32'h8, 32'hC);
        waitCycle("f8", memWord(32'h8), 32'hC);
        holdCycle("f8", 1'b1, 32'h8, memWord(32'h8), 32'hC);

        // Request backpressure for three cycles at 0xC.
        for (int i = 0; i < 3; i++) begin
            imem_req_ready = 1'b0;
            #1;
            checkOutput("bp_req_valid", 32'(imem_req_valid), 32'd1);
            checkOutput("bp_req_addr", imem_req_addr, 32'hC);
            checkOutput("bp_req_pc_next", pc_next, 32'hC);
            applyStimulus();
        end
        reqCycle("fC", 32'hC, 32'h10);
        waitCycle("fC", memWord(32'hC), 32'h10);
        // Decode stalls four cycles; the held instruction must not change.
        for (int i = 0; i < 4; i++) begin
            holdCycle("bp", 1'b0, 32'hC, memWord(32'hC), 32'h10);
        end
        holdCycle("fC", 1'b1, 32'hC, memWord(32'hC), 32'h10);

        // Redirect in HOLD to 0x203 with a same-cycle inst_ready.
        reqCycle("f10", 32'h10, 32'h14);
        waitCycle("f10", memWord(32'h10), 32'h14);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        holdCycle("rh", 1'b1, 32'h10, memWord(32'h10), 32'h200);
        redirect_valid = 1'b0;
        reqCycle("f200", 32'h200, 32'h204);
        waitCycle("f200", memWord(32'h200), 32'h204);
        holdCycle("f200", 1'b1, 32'h200, memWord(32'h200), 32'h204);

        // Redirect in REQ to the top word, then wrap to 0x0.
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        checkOutput("rq_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rq_pc_next", pc_next, 32'hFFFF_FFFC);
        applyStimulus();
        redirect_valid = 1'b0;
        reqCycle("wrap", 32'hFFFF_FFFC, 32'h0);
        waitCycle("wrap", memWord(32'hFFFF_FFFC), 32'h0);
        holdCycle("wrap", 1'b1, 32'hFFFF_FFFC, memWord(32'hFFFF_FFFC), 32'h0);
        reqCycle("after_wrap", 32'h0, 32'h4);

        // Reset asserted mid-WAIT, then a stale response during and after reset.
        #2;
        reset = 1'b1;
        #1;
        checkResetValues("async_reset");
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memWord(32'h0);
        applyStimulus();
        checkResetValues("in_reset");
        reset = 1'b0;
        #1;
        checkOutput("post_reset_pc_next", pc_next, 32'h0);
        checkOutput("post_reset_req_valid", 32'(imem_req_valid), 32'd0);
        applyStimulus();
        reqCycle("r0", 32'h0, 32'h4);
        waitCycle("r0", memWord(32'h0), 32'h4);
        holdCycle("r0", 1'b1, 32'h0, memWord(32'h0), 32'h4);
        reqCycle("r4", 32'h4, 32'h8);
        waitCycle("r4", memWord(32'h4), 32'h8);
        holdCycle("r4", 1'b1, 32'h4, memWord(32'h4), 32'h8);

        // Redirect in WAIT to 0x100 while 0x8 is outstanding.
        reqCycle("r8", 32'h8, 32'hC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        checkOutput("rw_pc_next", pc_next, 32'h100);
        checkOutput("rw_inst_valid", 32'(inst_valid), 32'd0);
        applyStimulus();
        redirect_valid = 1'b0;
        waitCycle("rw_stale", memWord(32'h8), 32'h100);
        reqCycle("f100", 32'h100, 32'h104);
        waitCycle("f100", memWord(32'h100), 32'h104);
        holdCycle("f100", 1'b1, 32'h100, memWord(32'h100), 32'h104);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
